set_assoc_cache: RTL

- Parametrised N-way set-associative cache with true-LRU replacement.
- Adds over the two-way block:
  - a valid/ready request channel
  - write-back, write-allocate policy with per-line dirty bits
  - a memory-side handshake for evictions and fills
- Sits between a core's load/store unit and the shared memory/interconnect port.

---
 rtl/set_assoc_cache.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/set_assoc_cache.sv
`default_nettype none
// ============================================================================
//  Module   : set_assoc_cache
//  Purpose  : N-way set-associative, write-back / write-allocate cache with
//             true-LRU replacement, a valid/ready request channel and a
//             memory-side handshake for writebacks and fills.
//  Ports    : clk_i, reset_i               - clock, sync active-high reset
//             req_valid_i/req_ready_o      - request handshake
//             req_we_i/addr_i/data_i       - request fields
//             resp_valid_o/hit_o/data_o    - one-cycle response strobe
//             mem_req_valid_o/ready_i      - memory request handshake
//             mem_we_o/addr_o/wdata_o      - writeback / fill request fields
//             mem_resp_valid_i/rdata_i     - fill data return
//  Revision : 1.0 - initial release
// ============================================================================
module set_assoc_cache #(
    parameter int BLOCK_SIZE = 32,
    parameter int NUM_BLOCKS = 16,
    parameter int NUM_WAYS   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [BLOCK_SIZE-1:0] req_data_i,
    output logic                  resp_valid_o,
    output logic                  resp_hit_o,
    output logic [BLOCK_SIZE-1:0] resp_data_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [BLOCK_SIZE-1:0] mem_wdata_o,
    input  logic                  mem_resp_valid_i,
    input  logic [BLOCK_SIZE-1:0] mem_rdata_i
);

    localparam int c_off_w  = $clog2(BLOCK_SIZE / 8);
    localparam int c_sets   = NUM_BLOCKS / NUM_WAYS;
    localparam int c_idx_w  = $clog2(c_sets);
    localparam int c_way_w  = $clog2(NUM_WAYS);
    localparam int c_tag_w  = ADDR_WIDTH - c_off_w - c_idx_w;
    localparam int c_line_w = c_idx_w + c_way_w;
    localparam logic [ADDR_WIDTH-1:0] c_blk_mask =
        ~((ADDR_WIDTH'(1) << c_off_w) - ADDR_WIDTH'(1));

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_lookup    = 3'd1;
    localparam logic [2:0] c_st_wb_req    = 3'd2;
    localparam logic [2:0] c_st_fill_req  = 3'd3;
    localparam logic [2:0] c_st_fill_wait = 3'd4;
    localparam logic [2:0] c_st_resp      = 3'd5;

    logic [2:0]            r_state, w_state_nxt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BLOCK_SIZE-1:0] r_wdata, r_fill;
    logic [c_way_w-1:0]    r_victim;

    // Line storage is flattened as {set, way} so a line number is a simple concatenation.
    logic [NUM_BLOCKS-1:0] r_valid, r_dirty;
    logic [c_tag_w-1:0]    r_tag  [NUM_BLOCKS];
    logic [BLOCK_SIZE-1:0] r_data [NUM_BLOCKS];
    logic [c_way_w-1:0]    r_age  [NUM_BLOCKS];

    logic [c_idx_w-1:0]    w_idx;
    logic [c_tag_w-1:0]    w_tag;
    logic                  w_hit, w_inv_found, w_victim_dirty;
    logic [c_way_w-1:0]    w_hit_way, w_inv_way, w_lru_way, w_victim;
    logic                  w_accept, w_hit_wr, w_install, w_touch_en;
    logic [c_way_w-1:0]    w_touch_way, w_touch_age;
    logic [c_line_w-1:0]   w_hit_line, w_vic_line, w_touch_line;

    function automatic logic [c_line_w-1:0] f_line(input logic [c_idx_w-1:0] idx,
                                                    input logic [c_way_w-1:0] way);
        return {idx, way};
    endfunction

    assign w_idx = r_addr[c_off_w +: c_idx_w];
    assign w_tag = r_addr[ADDR_WIDTH-1 -: c_tag_w];

    // Tag compare and victim choice; the descending loop leaves the lowest matching way.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_lru_way   = '0;
        for (int j = NUM_WAYS - 1; j >= 0; j--) begin
            if (r_valid[f_line(w_idx, c_way_w'(j))] &&
                r_tag[f_line(w_idx, c_way_w'(j))] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = c_way_w'(j);
            end
            if (!r_valid[f_line(w_idx, c_way_w'(j))]) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_way_w'(j);
            end
            if (r_age[f_line(w_idx, c_way_w'(j))] == c_way_w'(NUM_WAYS - 1)) begin
                w_lru_way = c_way_w'(j);
            end
        end
        w_victim = w_inv_found ? w_inv_way : w_lru_way;
    end

    assign w_hit_line     = f_line(w_idx, w_hit_way);
    assign w_vic_line     = f_line(w_idx, r_victim);
    assign w_victim_dirty = r_valid[f_line(w_idx, w_victim)] & r_dirty[f_line(w_idx, w_victim)];

    assign w_accept     = req_valid_i & req_ready_o;
    assign w_hit_wr     = !reset_i && r_state == c_st_lookup && w_hit && r_we;
    assign w_install    = !reset_i && r_state == c_st_resp;
    assign w_touch_en   = (r_state == c_st_lookup && w_hit) || r_state == c_st_resp;
    assign w_touch_way  = (r_state == c_st_resp) ? r_victim : w_hit_way;
    assign w_touch_line = f_line(w_idx, w_touch_way);
    assign w_touch_age  = r_age[w_touch_line];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:      if (req_valid_i) w_state_nxt = c_st_lookup;
            c_st_lookup: begin
                if (w_hit)               w_state_nxt = c_st_idle;
                else if (w_victim_dirty) w_state_nxt = c_st_wb_req;
                else if (r_we)           w_state_nxt = c_st_resp;
                else                     w_state_nxt = c_st_fill_req;
            end
            c_st_wb_req:    if (mem_req_ready_i) w_state_nxt = r_we ? c_st_resp : c_st_fill_req;
            c_st_fill_req:  if (mem_req_ready_i) w_state_nxt = c_st_fill_wait;
            c_st_fill_wait: if (mem_resp_valid_i) w_state_nxt = c_st_resp;
            c_st_resp:      w_state_nxt = c_st_idle;
            default:        w_state_nxt = c_st_idle;
        endcase
    end

    // Every output is held low while reset is asserted, whatever the state.
    always_comb begin
        req_ready_o     = 1'b0;
        resp_valid_o    = 1'b0;
        resp_hit_o      = 1'b0;
        resp_data_o     = '0;
        mem_req_valid_o = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        if (!reset_i) begin
            case (r_state)
                c_st_idle: req_ready_o = 1'b1;
                c_st_lookup: begin
                    if (w_hit) begin
                        resp_valid_o = 1'b1;
                        resp_hit_o   = 1'b1;
                        resp_data_o  = r_we ? r_wdata : r_data[w_hit_line];
                    end
                end
                c_st_wb_req: begin
                    mem_req_valid_o = 1'b1;
                    mem_we_o        = 1'b1;
                    mem_addr_o      = ADDR_WIDTH'({r_tag[w_vic_line], w_idx}) << c_off_w;
                    mem_wdata_o     = r_data[w_vic_line];
                end
                c_st_fill_req: begin
                    mem_req_valid_o = 1'b1;
                    mem_addr_o      = r_addr & c_blk_mask;
                end
                c_st_resp: begin
                    resp_valid_o = 1'b1;
                    resp_data_o  = r_we ? r_wdata : r_fill;
                end
                default: ;
            endcase
        end
    end

    // Control state: FSM, valid/dirty bits and LRU ages.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_st_idle;
            r_valid <= '0;
            r_dirty <= '0;
            for (int l = 0; l < NUM_BLOCKS; l++) begin
                r_age[l] <= c_way_w'(l % NUM_WAYS);
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_hit_wr) begin
                r_dirty[w_hit_line] <= 1'b1;
            end
            if (w_install) begin
                r_valid[w_vic_line] <= 1'b1;
                r_dirty[w_vic_line] <= r_we;
            end
            // Ways younger than the touched one age by one; the touched way becomes youngest.
            if (w_touch_en) begin
                for (int j = 0; j < NUM_WAYS; j++) begin
                    if (r_age[f_line(w_idx, c_way_w'(j))] < w_touch_age) begin
                        r_age[f_line(w_idx, c_way_w'(j))] <=
                            r_age[f_line(w_idx, c_way_w'(j))] + c_way_w'(1);
                    end
                end
                r_age[w_touch_line] <= '0;
            end
        end
    end

    // Datapath: request latch, fill capture, tag and data arrays (no reset needed).
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_we    <= req_we_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_data_i;
        end
        if (r_state == c_st_lookup) begin
            r_victim <= w_victim;
        end
        if (r_state == c_st_fill_wait && mem_resp_valid_i) begin
            r_fill <= mem_rdata_i;
        end
        if (w_hit_wr) begin
            r_data[w_hit_line] <= r_wdata;
        end
        if (w_install) begin
            r_data[w_vic_line] <= r_we ? r_wdata : r_fill;
            r_tag[w_vic_line]  <= w_tag;
        end
    end

endmodule
`default_nettype wire
